alu_arbiter: RTL

Shares the single registered ALU between two requesters (req0 = integer execute stage, req1 = branch/address unit) using round-robin arbitration and valid/ready handshakes. It sequences each operation through the ALU's one-cycle registered latency. For the divide-class ops (`DIV`, `DIVU`, `REMU` from aluops.vh) it holds operands stable for a programmable multicycle window before presenting the result. It sits between the requesters and the ALU instance, drives all ALU inputs, and returns tagged results with backpressure.

---
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester/consumer side of the ALU arbiter: two request channels and one
// tagged response channel, each with a valid/ready handshake.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_res;
  logic        rsp_zero;

  // Requesters and the result consumer
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_res, rsp_zero
  );

  // The arbiter itself
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_res, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Each grant latches the operands into the ALU input registers, waits out the
// ALU latency (a longer multicycle window for divide-class ops), then presents
// the result tagged with the requester index until the consumer takes it.
module alu_arbiter #(
  parameter int         DIV_LAT = 4,      // legal range 1..15
  parameter logic [4:0] NOP_OP  = 5'h1F,
  parameter logic [4:0] OP_DIV  = 5'h0C,
  parameter logic [4:0] OP_DIVU = 5'h0D,
  parameter logic [4:0] OP_REMU = 5'h0F
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic [4:0]    alu_op,
  output logic [31:0]   alu_r1,
  output logic [31:0]   alu_r2,
  input  logic [31:0]   alu_res,
  input  logic          alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        prio;
  logic [3:0]  cnt;
  logic        id;

  logic        any_valid;
  logic        pick1;
  logic [4:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        div_class;

  // Winner selection: prio only matters when both requesters contend
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    pick1     = bus.req1_valid & (~bus.req0_valid | prio);
    sel_op    = pick1 ? bus.req1_op : bus.req0_op;
    sel_a     = pick1 ? bus.req1_a  : bus.req0_a;
    sel_b     = pick1 ? bus.req1_b  : bus.req0_b;
    div_class = (sel_op == OP_DIV) | (sel_op == OP_DIVU) | (sel_op == OP_REMU);
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held
  assign bus.req0_ready = rst_n & (state == IDLE) & bus.req0_valid & ~pick1;
  assign bus.req1_ready = rst_n & (state == IDLE) & pick1;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id;
  assign bus.rsp_res    = alu_res;
  assign bus.rsp_zero   = alu_zero;
  assign busy           = (state != IDLE);

  // Grant, latency countdown and response hold sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      cnt    <= 4'd0;
      alu_op <= NOP_OP;
      alu_r1 <= 32'd0;
      alu_r2 <= 32'd0;
      id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_op <= sel_op;
            alu_r1 <= sel_a;
            alu_r2 <= sel_b;
            id     <= pick1;
            prio   <= ~pick1;
            cnt    <= div_class ? 4'(DIV_LAT) : 4'd1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          // No grant in the handshake cycle; IDLE is always visited
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
